// File: rtl/systolic_seq_ctrl.sv
// Pass sequencer for the systolic array: clear, kernel load, settle gap, execute, drain, done.
// All outputs are registered from the next state so they line up with the state they belong to.
module systolic_seq_ctrl #(
  parameter int unsigned col     = 8,
  parameter int unsigned row     = 8,
  parameter int unsigned num_act = 36,
  parameter int unsigned addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode_in,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               mode,
  output logic [1:0]         inst_w,
  output logic               array_reset,
  output logic               w_cen,
  output logic [addr_bw-1:0] w_addr,
  output logic               a_cen,
  output logic [addr_bw-1:0] a_addr
);

  localparam int unsigned LOAD_MAX = 2 * col;
  localparam int unsigned DRAIN_LEN = row + col;
  localparam int unsigned MAX_LEN =
    (LOAD_MAX > DRAIN_LEN) ? ((LOAD_MAX > num_act) ? LOAD_MAX : num_act)
                           : ((DRAIN_LEN > num_act) ? DRAIN_LEN : num_act);
  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_GAP   = 3'd3,
    S_EXEC  = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   load_last;
  logic               abort_hit;

  logic               busy_d, done_d, mode_d, array_reset_d, w_cen_d, a_cen_d;
  logic [1:0]         inst_w_d;
  logic [addr_bw-1:0] w_addr_d, a_addr_d;

  assign load_last = mode ? CNT_W'(2 * col - 1) : CNT_W'(col - 1);

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mode        <= 1'b0;
      inst_w      <= 2'b00;
      array_reset <= 1'b0;
      w_cen       <= 1'b1;
      w_addr      <= '0;
      a_cen       <= 1'b1;
      a_addr      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy        <= busy_d;
      done        <= done_d;
      mode        <= mode_d;
      inst_w      <= inst_w_d;
      array_reset <= array_reset_d;
      w_cen       <= w_cen_d;
      w_addr      <= w_addr_d;
      a_cen       <= a_cen_d;
      a_addr      <= a_addr_d;
    end
  end

  // Next state; abort overrides every non-idle transition
  always_comb begin
    state_d   = state_q;
    abort_hit = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_LOAD;
      S_LOAD:  if (cnt_q == load_last) state_d = S_GAP;
      S_GAP:   if (cnt_q == CNT_W'(col - 1)) state_d = S_EXEC;
      S_EXEC:  if (cnt_q == CNT_W'(num_act - 1)) state_d = S_DRAIN;
      S_DRAIN: if (cnt_q == CNT_W'(DRAIN_LEN - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      abort_hit = 1'b1;
    end
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Output values for the coming cycle; inst_w trails the SRAM strobes by one cycle
  always_comb begin
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    mode_d        = mode;
    array_reset_d = (state_d == S_CLEAR) || abort_hit;
    w_cen_d       = 1'b1;
    w_addr_d      = w_addr;
    a_cen_d       = 1'b1;
    a_addr_d      = a_addr;
    inst_w_d      = abort_hit ? 2'b00 : {~a_cen, ~w_cen};
    if ((state_q == S_IDLE) && start) mode_d = mode_in;
    if (state_d == S_LOAD) begin
      w_cen_d  = 1'b0;
      w_addr_d = addr_bw'(cnt_d);
    end
    if (state_d == S_EXEC) begin
      a_cen_d  = 1'b0;
      a_addr_d = addr_bw'(cnt_d);
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomized bench for systolic_seq_ctrl against a cycle-offset reference model of one pass.
module tb_systolic_seq_ctrl;

  localparam int COL = 8;
  localparam int ROW = 8;
  localparam int NACT = 36;
  localparam int ABW = 11;

  logic           clk = 1'b0;
  logic           reset;
  logic           start, mode_in, abort;
  logic           busy, done, mode, array_reset, w_cen, a_cen;
  logic [1:0]     inst_w;
  logic [ABW-1:0] w_addr, a_addr;

  int checks = 0;
  int errors = 0;

  // Model: a pass is described by its offset k from the accepted start cycle
  bit m_active;
  int m_k;
  bit m_mode;
  bit m_abort_flag;
  int m_last_w;
  int m_last_a;

  systolic_seq_ctrl #(.col(COL), .row(ROW), .num_act(NACT), .addr_bw(ABW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in), .abort(abort),
    .busy(busy), .done(done), .mode(mode), .inst_w(inst_w), .array_reset(array_reset),
    .w_cen(w_cen), .w_addr(w_addr), .a_cen(a_cen), .a_addr(a_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int load_len();
    return m_mode ? 2 * COL : COL;
  endfunction

  function automatic int pass_len();
    return 1 + load_len() + COL + NACT + ROW + COL + 1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_k = 0; m_mode = 0; m_abort_flag = 0; m_last_w = 0; m_last_a = 0;
  endtask

  // Advance the model across one rising edge with the inputs applied before it
  task automatic model_step(input bit st, input bit ab, input bit mi);
    if (!m_active) begin
      m_abort_flag = 0;
      if (st) begin
        m_active = 1; m_k = 1; m_mode = mi;
      end
    end else if (ab) begin
      m_active = 0; m_abort_flag = 1;
    end else begin
      m_abort_flag = 0;
      m_k++;
      if (m_k > pass_len()) m_active = 0;
    end
  endtask

  task automatic check_outputs();
    int w, e0;
    bit in_load, in_exec;
    w  = load_len();
    e0 = 2 + w + COL;
    in_load = m_active && m_k >= 2 && m_k <= 1 + w;
    in_exec = m_active && m_k >= e0 && m_k <= e0 + NACT - 1;
    if (in_load) m_last_w = m_k - 2;
    if (in_exec) m_last_a = m_k - e0;
    check("busy", busy, m_active);
    check("done", done, m_active && m_k == pass_len());
    check("mode", mode, m_mode);
    check("array_reset", array_reset, m_abort_flag || (m_active && m_k == 1));
    check("w_cen", w_cen, !in_load);
    check("w_addr", w_addr, m_last_w);
    check("a_cen", a_cen, !in_exec);
    check("a_addr", a_addr, m_last_a);
    check("inst_w0", inst_w[0], m_active && m_k >= 3 && m_k <= 2 + w);
    check("inst_w1", inst_w[1], m_active && m_k >= e0 + 1 && m_k <= e0 + NACT);
  endtask

  task automatic step(input bit st, input bit ab, input bit mi);
    start = st; abort = ab; mode_in = mi;
    @(posedge clk);
    model_step(st, ab, mi);
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  // Run one full pass; optionally hammer start/mode_in while busy
  task automatic run_pass(input bit mi, input bit noisy);
    int budget;
    step(1'b1, 1'b0, mi);
    budget = 0;
    while (m_active && budget < 200) begin
      if (noisy) step(1'b1, 1'b0, 1'(budget & 1));
      else       step(1'b0, 1'b0, 1'b0);
      budget++;
    end
    check("pass_bounded", int'(budget < 200), 1);
  endtask

  initial begin
    model_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode_in = 1'b0;
    #12;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(2);

    // Directed passes: mode 0, mode 1, and start/mode_in noise while busy
    run_pass(1'b0, 1'b0);
    idle_cycles(3);
    run_pass(1'b1, 1'b0);
    idle_cycles(1);
    run_pass(1'b0, 1'b1);
    idle_cycles(2);

    // Abort in EXEC while a_addr=10 is presented
    step(1'b1, 1'b0, 1'b0);
    while (m_active && m_k < 2 + COL + COL + 10) step(1'b0, 1'b0, 1'b0);
    check("abort_point_addr", a_addr, 10);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_pass(1'b1, 1'b0);

    // Abort together with start in IDLE: start wins
    step(1'b1, 1'b1, 1'b1);
    idle_cycles(5);
    step(1'b0, 1'b1, 1'b0);
    idle_cycles(2);

    // Async reset between edges in the middle of LOAD
    step(1'b1, 1'b0, 1'b1);
    idle_cycles(4);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(2);
    run_pass(1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bit st, ab;
      st = ($urandom_range(0, 9) == 0);
      ab = m_active ? ($urandom_range(0, 119) == 0) : ($urandom_range(0, 19) == 0);
      step(st, ab, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
